// File: rtl/datamem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the 32-word data memory.
// Each grant drives the memory for one full ACCESS cycle; the result returns with a one-cycle ack.
module datamem_arbiter #(
    parameter int unsigned MEM_DEPTH = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic              m0_err,
    output logic              m1_err,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_q,    state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              win_q,      win_d;
    logic              we_q,       we_d;
    logic              oob_q,      oob_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              m0_ack_q,   m0_ack_d;
    logic              m1_ack_q,   m1_ack_d;
    logic              m0_err_q,   m0_err_d;
    logic              m1_err_q,   m1_err_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

    logic              access;
    logic              sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] rd_val;

    assign access = (state_q == ACCESS);

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        win_d      = win_q;
        we_d       = we_q;
        oob_d      = oob_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_err_d   = m0_err_q;
        m1_err_d   = m1_err_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        // On a tie the port that did not win last time goes next.
        sel        = (m0_req && m1_req) ? ~last_gnt_q : m1_req;
        sel_addr   = sel ? m1_addr : m0_addr;
        rd_val     = (we_q || oob_q) ? '0 : mem_rdata;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d    = ACCESS;
                    win_d      = sel;
                    last_gnt_d = sel;
                    we_d       = sel ? m1_we : m0_we;
                    addr_d     = sel_addr;
                    wdata_d    = sel ? m1_wdata : m0_wdata;
                    oob_d      = (sel_addr >= ADDR_W'(MEM_DEPTH));
                end
            end
            ACCESS: begin
                state_d = IDLE;
                if (win_q) begin
                    m1_ack_d   = 1'b1;
                    m1_err_d   = oob_q;
                    m1_rdata_d = rd_val;
                end else begin
                    m0_ack_d   = 1'b1;
                    m0_err_d   = oob_q;
                    m0_rdata_d = rd_val;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            oob_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            win_q      <= win_d;
            we_q       <= we_d;
            oob_q      <= oob_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_err_q   <= m0_err_d;
            m1_err_q   <= m1_err_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Memory controls come straight from state so an async reset drops them at once.
    assign m0_gnt    = access && !win_q;
    assign m1_gnt    = access &&  win_q;
    assign mem_write = access &&  we_q && !oob_q;
    assign mem_read  = access && !we_q && !oob_q;
    assign mem_addr  = access ? addr_q  : '0;
    assign mem_wdata = access ? wdata_q : '0;

    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign m0_err    = m0_err_q;
    assign m1_err    = m1_err_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: doc/datamem_arbiter.md
# datamem_arbiter

Two-port arbiter and sequencer for the 32-word data memory `datamem`. Port 0 is the CPU load/store stage and port 1 is the debug/DMA loader. The block grants one requester at a time with round-robin fairness and drives `datamem`'s `MemWrite`, `Memread`, `address` and `writeData` for exactly one full clock. It registers `readData` and returns it with a one-cycle acknowledge. It also rejects out-of-range addresses without touching memory.

## Interface
- `MEM_DEPTH`, 32: number of memory words; addresses >= MEM_DEPTH are errors.
- `DATA_W`, 32: data width.
- `ADDR_W`, 32: address width.
- `clk` in 1: system clock. All state updates on the rising edge; `datamem` writes on the falling edge.
- `rst_n` in 1: **one clock; reset is asynchronous and active-low.**
- `m0_req`, `m1_req` in 1: access request, level, sampled in IDLE.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read. Valid while req=1.
- `m0_addr`, `m1_addr` in ADDR_W: word address.
- `m0_wdata`, `m1_wdata` in DATA_W: write data.
- `m0_gnt`, `m1_gnt` out 1: high for the single ACCESS cycle serving that port.
- `m0_ack`, `m1_ack` out 1: one-cycle pulse, the cycle after ACCESS.
- `m0_err`, `m1_err` out 1: valid with ack; 1 = address out of range.
- `m0_rdata`, `m1_rdata` out DATA_W: read result, valid with ack; held until that port's next ack.
- `mem_write` out 1: to `datamem` MemWrite.
- `mem_read` out 1: to `datamem` Memread.
- `mem_addr` out ADDR_W: to `datamem` address.
- `mem_wdata` out DATA_W: to `datamem` writeData.
- `mem_rdata` in DATA_W: from `datamem` readData (combinational read).

## Operation
- FSM has two states.
- **IDLE**: if any req=1, choose the winner, latch its we/addr/wdata into command registers, compute `oob = (addr >= MEM_DEPTH)`, and go to ACCESS. Otherwise stay in IDLE.
- **ACCESS**: drive memory from the latched command for the whole cycle, then return to IDLE unconditionally.
- Arbitration:
  - One requester: it wins.
  - Both requesting: the port not in `last_gnt` wins.
  - `last_gnt` updates to the winner on every grant.
- Memory drive in ACCESS:
  - `mem_addr` = latched addr; `mem_wdata` = latched wdata.
  - `mem_write` = we & ~oob; `mem_read` = ~we & ~oob.
- Memory drive outside ACCESS: all mem_* outputs are 0, so `datamem` returns 0 and no write occurs.
- On the rising edge ending ACCESS, for the winner port:
  - ack <= 1.
  - err <= oob.
  - rdata <= (we | oob) ? 0 : mem_rdata.
- The other port's rdata is unchanged.
- Requester rule: hold req and command stable until gnt is seen. Drop req by the next rising edge unless a further access is wanted. Req still high in the ack/IDLE cycle counts as a new request.
- Commands changing after latching have no effect on the access in flight.

## Timing
- Reset (async, immediate) values:
  - State IDLE; `last_gnt` = port 1, so port 0 wins the first tie.
  - All gnt, ack, err, rdata, mem_* outputs = 0.
- Latency:
  - Req high in IDLE cycle T → gnt and memory access in T+1 → ack/err/rdata in T+2.
- Memory write commits at the falling edge inside cycle T+1.
- Throughput: one access per 2 cycles. Back-to-back accesses alternate ACCESS and IDLE; the IDLE cycle coincides with the previous ack.
- Continuous requests from both ports alternate strictly: 0, 1, 0, 1, …
- Reset asserted during ACCESS:
  - mem_write drops immediately; if this happens before the falling edge, no write occurs.
  - No ack is issued; the FSM returns to IDLE.
- Addresses are not truncated; any address >= MEM_DEPTH, including 32'hFFFFFFFF, gives err=1.

## Test plan
- Reset, then `m0` read addr 1 → gnt0 one cycle later; ack0 two cycles after req with rdata0 = 32'h0000000F, err0 = 0; mem_read high only in ACCESS.
- `m1` write addr 20 data 32'hDEADBEEF, then `m1` read addr 20 → second ack1 returns rdata1 = 32'hDEADBEEF; rdata0 unchanged.
- `m0` and `m1` both request reads continuously from the first cycle after reset → gnt order 0, 1, 0, 1; an ack every 2nd cycle; no cycle with both gnts high.
- `m0` write addr 32 data 32'h12345678 → ack0 with err0 = 1, rdata0 = 0; mem_write never asserted; later read of addr 0 returns 32'h80000001.
- Write addr 5 data 32'hA5A5A5A5 with rst_n pulsed low during the first half of ACCESS → no ack; outputs return to 0; subsequent read of addr 5 returns 32'h00000005.
